// File: rtl/uart_prefix_looper.sv
// Loops i over 0..I_LAST-1 and sends the first min(i+PREFIX_OFS, N_CHARS) message bytes
// per pass as 8N1 UART frames, then reports the exit value of i through a ready handshake.
module uart_prefix_looper #(
  parameter int N_CHARS      = 12,
  parameter int CLKS_PER_BIT = 434,
  parameter int IW           = 4,
  parameter int I_LAST       = 11,
  parameter int PREFIX_OFS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*N_CHARS-1:0] msg,
  output logic                 txd,
  output logic                 busy,
  output logic [IW-1:0]        result,
  output logic                 result_ready
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int KW = $clog2(N_CHARS + 1);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_EXIT     = IW'(I_LAST);
  localparam logic [KW-1:0] N_FULL     = KW'(N_CHARS);

  typedef enum logic [2:0] {
    READY,
    INIT,
    RESTART,
    TEST,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] i;
  logic [KW-1:0] k;
  logic [KW-1:0] n;
  logic [KW-1:0] n_next;
  logic [TW-1:0] bit_tmr;
  logic [2:0]    bit_idx;
  logic [31:0]   prefix_sum;
  logic [7:0]    cur_byte;
  logic          line_bit;
  logic          tick;

  // Prefix length is formed in a wide sum so a large offset saturates instead of wrapping.
  assign prefix_sum = 32'(i) + 32'(PREFIX_OFS);
  assign n_next     = (prefix_sum >= 32'(N_CHARS)) ? N_FULL : prefix_sum[KW-1:0];
  assign cur_byte   = msg[{k, 3'b000} +: 8];
  assign tick       = (bit_tmr == '0);

  assign busy         = (state != READY);
  assign result_ready = (state == READY) && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    line_bit   = 1'b1;
    case (state)
      READY: begin
        state_next = READY;
      end
      INIT: begin
        state_next = RESTART;
      end
      RESTART: begin
        state_next = TEST;
      end
      TEST: begin
        if (i == I_EXIT) begin
          state_next = READY;
        end else if (k == n) begin
          state_next = RESTART;
        end else begin
          state_next = START_BIT;
        end
      end
      START_BIT: begin
        line_bit = 1'b0;
        if (tick) state_next = DATA_BITS;
      end
      DATA_BITS: begin
        line_bit = cur_byte[bit_idx];
        if (tick && (bit_idx == 3'd7)) state_next = STOP_BIT;
      end
      STOP_BIT: begin
        if (tick) state_next = TEST;
      end
      default: begin
        state_next = READY;
      end
    endcase
    if (start) state_next = INIT;
  end

  // txd is a registered copy of the state's line level, so it trails the state by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      i       <= '0;
      k       <= '0;
      n       <= '0;
      bit_tmr <= '0;
      bit_idx <= '0;
      result  <= '0;
      txd     <= 1'b1;
    end else if (start) begin
      i       <= '0;
      k       <= '0;
      n       <= '0;
      bit_tmr <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      txd <= line_bit;
      case (state)
        INIT: begin
          i <= '0;
        end
        RESTART: begin
          k <= '0;
          n <= n_next;
        end
        TEST: begin
          if (i == I_EXIT) begin
            result <= i;
          end else if (k == n) begin
            i <= i + 1'b1;
          end else begin
            bit_tmr <= TMR_RELOAD;
            bit_idx <= '0;
          end
        end
        START_BIT: begin
          bit_tmr <= tick ? TMR_RELOAD : bit_tmr - 1'b1;
        end
        DATA_BITS: begin
          bit_tmr <= tick ? TMR_RELOAD : bit_tmr - 1'b1;
          if (tick) bit_idx <= bit_idx + 1'b1;
        end
        STOP_BIT: begin
          if (tick) begin
            k <= k + 1'b1;
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prefix_looper.sv
// Bench for uart_prefix_looper: four parameterisations, a UART line decoder, and a
// reference model that derives byte streams and run lengths from the loop rules.
module tb_uart_prefix_looper;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  start_v;
  logic [3:0]  txd_v;
  logic [3:0]  busy_v;
  logic [3:0]  rdy_v;
  logic [3:0]  res_v [4];
  logic [95:0] msg_a;
  logic [95:0] msg_b;
  logic [95:0] msg_c;
  logic [23:0] msg_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_prefix_looper #(.N_CHARS(12), .CLKS_PER_BIT(4), .IW(4), .I_LAST(11), .PREFIX_OFS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .msg(msg_a), .txd(txd_v[0]),
    .busy(busy_v[0]), .result(res_v[0]), .result_ready(rdy_v[0]));

  uart_prefix_looper #(.N_CHARS(12), .CLKS_PER_BIT(4), .IW(4), .I_LAST(0), .PREFIX_OFS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .msg(msg_b), .txd(txd_v[1]),
    .busy(busy_v[1]), .result(res_v[1]), .result_ready(rdy_v[1]));

  uart_prefix_looper #(.N_CHARS(12), .CLKS_PER_BIT(4), .IW(4), .I_LAST(3), .PREFIX_OFS(20)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .msg(msg_c), .txd(txd_v[2]),
    .busy(busy_v[2]), .result(res_v[2]), .result_ready(rdy_v[2]));

  uart_prefix_looper #(.N_CHARS(3), .CLKS_PER_BIT(2), .IW(4), .I_LAST(5), .PREFIX_OFS(0)) dut_d (
    .clk(clk), .reset(reset), .start(start_v[3]), .msg(msg_d), .txd(txd_v[3]),
    .busy(busy_v[3]), .result(res_v[3]), .result_ready(rdy_v[3]));

  // Idle instances hold their line high, so the AND of all lines is the active one.
  logic       mon_txd;
  logic       mon_rst;
  int         mon_cpb;
  logic [7:0] rx_q [$];
  int         frame_err = 0;
  bit         m_act = 0;
  int         m_cnt;
  logic [7:0] m_sh;
  logic [7:0] mb [$];
  logic [7:0] exp_q [$];

  assign mon_txd = &txd_v;

  always @(negedge clk) begin
    if (reset || mon_rst) begin
      m_act = 0;
    end else if (!m_act) begin
      if (mon_txd == 1'b0) begin
        m_act = 1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == mon_cpb / 2 && mon_txd !== 1'b0) begin
        frame_err++;
        m_act = 0;
      end else if (m_cnt >= mon_cpb && m_cnt < 9 * mon_cpb &&
                   ((m_cnt - mon_cpb) % mon_cpb) == mon_cpb / 2) begin
        m_sh[(m_cnt - mon_cpb) / mon_cpb] = mon_txd;
      end else if (m_cnt == 9 * mon_cpb + mon_cpb / 2) begin
        if (mon_txd === 1'b1) rx_q.push_back(m_sh);
        else frame_err++;
        m_act = 0;
      end
    end
  end

  function automatic int pre_len(int i, int nch, int pofs);
    return (i + pofs < nch) ? i + pofs : nch;
  endfunction

  function automatic int model_cycles(int nch, int cpb, int ilast, int pofs);
    int tot = 3;
    for (int i = 0; i < ilast; i++) tot += 2 + pre_len(i, nch, pofs) * (10 * cpb + 1);
    return tot;
  endfunction

  task automatic model_bytes(input int nch, input int ilast, input int pofs);
    exp_q.delete();
    for (int i = 0; i < ilast; i++)
      for (int k = 0; k < pre_len(i, nch, pofs); k++) exp_q.push_back(mb[k]);
  endtask

  function automatic int first_mismatch(int base);
    if (rx_q.size() - base != exp_q.size()) return -2;
    for (int j = 0; j < exp_q.size(); j++) if (rx_q[base + j] !== exp_q[j]) return j;
    return -1;
  endfunction

  task automatic load_hello();
    string s = "\r\nHelloWorld";
    mb.delete();
    for (int k = 0; k < 12; k++) mb.push_back(s[k]);
  endtask

  task automatic load_random(input int nbytes);
    mb.delete();
    for (int k = 0; k < nbytes; k++) mb.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk);
    #1 start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
  endtask

  task automatic run_to_ready(input int d, input int limit, output int busy_cyc,
                              output int rises, output int low_cyc, output bit timed_out);
    logic prev = rdy_v[d];
    busy_cyc  = 0;
    rises     = 0;
    low_cyc   = 0;
    timed_out = 1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (rdy_v[d] && !prev) rises++;
      prev = rdy_v[d];
      if (txd_v[d] === 1'b0) low_cyc++;
      if (busy_v[d]) busy_cyc++;
      else begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_v = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (txd_v !== 4'hF) begin failures++; $display("[TB] FAIL reset_txd got=%b want=1111", txd_v); end
    checks++;
    if (busy_v !== 4'h0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0000", busy_v); end
    checks++;
    if (rdy_v !== 4'hF) begin failures++; $display("[TB] FAIL reset_ready got=%b want=1111", rdy_v); end
    checks++;
    if (res_v[0] !== 4'd0 || res_v[2] !== 4'd0) begin
      failures++; $display("[TB] FAIL reset_result got=%0d/%0d want=0", res_v[0], res_v[2]);
    end
    @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL ready_with_start got=%b want=0", rdy_v[0]); end
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_priority got=%b want=0", busy_v[0]); end
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_bit_timing();
    int  bad_k = -1;
    int  bc, rs, lc;
    bit  to;
    logic want;
    mon_cpb = 4;
    load_hello();
    for (int k = 0; k < 12; k++) msg_a[8*k +: 8] = mb[k];
    @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int e = 0; e < 44; e++) begin
      @(negedge clk);
      if (e < 4) want = 1'b1;
      else if ((e - 4) / 4 == 0) want = 1'b0;
      else if ((e - 4) / 4 == 9) want = 1'b1;
      else want = mb[0][(e - 4) / 4 - 1];
      if (txd_v[0] !== want && bad_k < 0) bad_k = e;
    end
    checks++;
    if (bad_k >= 0) begin
      failures++; $display("[TB] FAIL bit_timing first wrong cycle=%0d want none", bad_k);
    end
    run_to_ready(0, 20000, bc, rs, lc, to);
    checks++;
    if (to || res_v[0] !== 4'd11) begin
      failures++; $display("[TB] FAIL bit_timing_result got=%0d timeout=%0d want=11", res_v[0], to);
    end
  endtask

  task automatic test_full_run();
    int base = rx_q.size();
    int fe0  = frame_err;
    int bc, rs, lc, mm;
    bit to;
    load_hello();
    for (int k = 0; k < 12; k++) msg_a[8*k +: 8] = mb[k];
    pulse_start(0);
    checks++;
    if (res_v[0] !== 4'd11) begin failures++; $display("[TB] FAIL result_held got=%0d want=11", res_v[0]); end
    run_to_ready(0, 20000, bc, rs, lc, to);
    model_bytes(12, 11, 2);
    mm = first_mismatch(base);
    checks++;
    if (to || bc != model_cycles(12, 4, 11, 2)) begin
      failures++; $display("[TB] FAIL full_cycles got=%0d want=%0d", bc, model_cycles(12, 4, 11, 2));
    end
    checks++;
    if (mm != -1) begin
      failures++; $display("[TB] FAIL full_bytes got=%0d bytes (bad idx %0d) want=%0d", rx_q.size() - base, mm, exp_q.size());
    end
    checks++;
    if (res_v[0] !== 4'd11) begin failures++; $display("[TB] FAIL full_result got=%0d want=11", res_v[0]); end
    checks++;
    if (rs != 1) begin failures++; $display("[TB] FAIL ready_rises got=%0d want=1", rs); end
    checks++;
    if (frame_err != fe0) begin failures++; $display("[TB] FAIL full_framing got=%0d want=%0d", frame_err, fe0); end
  endtask

  task automatic test_ilast_zero();
    int bc, rs, lc;
    bit to;
    msg_b = {$urandom, $urandom, $urandom};
    pulse_start(1);
    run_to_ready(1, 100, bc, rs, lc, to);
    repeat (5) @(negedge clk);
    checks++;
    if (to || bc != model_cycles(12, 4, 0, 2)) begin
      failures++; $display("[TB] FAIL ilast0_busy got=%0d want=%0d", bc, model_cycles(12, 4, 0, 2));
    end
    checks++;
    if (lc != 0 || txd_v[1] !== 1'b1) begin failures++; $display("[TB] FAIL ilast0_txd low cycles=%0d want=0", lc); end
    checks++;
    if (res_v[1] !== 4'd0 || rdy_v[1] !== 1'b1) begin
      failures++; $display("[TB] FAIL ilast0_result got=%0d ready=%b want=0 ready=1", res_v[1], rdy_v[1]);
    end
  endtask

  task automatic test_restart();
    int base, bc, rs, lc, mm, waited;
    bit to;
    load_hello();
    for (int k = 0; k < 12; k++) msg_a[8*k +: 8] = mb[k];
    base = rx_q.size();
    pulse_start(0);
    waited = 0;
    while (rx_q.size() - base < 5 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 2000) begin failures++; $display("[TB] FAIL restart_wait got=%0d bytes want=5", rx_q.size() - base); end
    repeat (8) @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin failures++; $display("[TB] FAIL restart_midrun busy got=%b want=1", busy_v[0]); end
    @(posedge clk);
    #1 start_v[0] = 1'b1;
    mon_rst = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    mon_rst = 1'b0;
    base = rx_q.size();
    @(negedge clk);
    checks++;
    if (txd_v[0] !== 1'b1 || res_v[0] !== 4'd11) begin
      failures++; $display("[TB] FAIL restart_abort txd=%b result=%0d want txd=1 result=11", txd_v[0], res_v[0]);
    end
    run_to_ready(0, 20000, bc, rs, lc, to);
    model_bytes(12, 11, 2);
    mm = first_mismatch(base);
    checks++;
    if (to || mm != -1 || res_v[0] !== 4'd11) begin
      failures++; $display("[TB] FAIL restart_rerun bytes=%0d bad idx=%0d result=%0d want bytes=%0d result=11",
                           rx_q.size() - base, mm, res_v[0], exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int base, bc, rs, lc, mm;
    bit to;
    load_random(12);
    for (int k = 0; k < 12; k++) msg_a[8*k +: 8] = mb[k];
    pulse_start(0);
    repeat (100 + $urandom_range(0, 60)) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || res_v[0] !== 4'd0 || rdy_v[0] !== 1'b1) begin
      failures++; $display("[TB] FAIL midreset got txd=%b busy=%b result=%0d ready=%b want 1,0,0,1",
                           txd_v[0], busy_v[0], res_v[0], rdy_v[0]);
    end
    base = rx_q.size();
    pulse_start(0);
    run_to_ready(0, 20000, bc, rs, lc, to);
    model_bytes(12, 11, 2);
    mm = first_mismatch(base);
    checks++;
    if (to || bc != model_cycles(12, 4, 11, 2)) begin
      failures++; $display("[TB] FAIL midreset_cycles got=%0d want=%0d", bc, model_cycles(12, 4, 11, 2));
    end
    checks++;
    if (mm != -1 || res_v[0] !== 4'd11) begin
      failures++; $display("[TB] FAIL midreset_rerun bad idx=%0d result=%0d want idx=-1 result=11", mm, res_v[0]);
    end
  endtask

  task automatic test_prefix_saturation();
    int base = rx_q.size();
    int bc, rs, lc, mm;
    bit to;
    load_random(12);
    for (int k = 0; k < 12; k++) msg_c[8*k +: 8] = mb[k];
    pulse_start(2);
    run_to_ready(2, 20000, bc, rs, lc, to);
    model_bytes(12, 3, 20);
    mm = first_mismatch(base);
    checks++;
    if (to || bc != model_cycles(12, 4, 3, 20)) begin
      failures++; $display("[TB] FAIL sat_cycles got=%0d want=%0d", bc, model_cycles(12, 4, 3, 20));
    end
    checks++;
    if (mm != -1) begin
      failures++; $display("[TB] FAIL sat_bytes got=%0d bytes (bad idx %0d) want=%0d", rx_q.size() - base, mm, exp_q.size());
    end
    checks++;
    if (res_v[2] !== 4'd3) begin failures++; $display("[TB] FAIL sat_result got=%0d want=3", res_v[2]); end
  endtask

  task automatic test_zero_prefix();
    int base = rx_q.size();
    int bc, rs, lc, mm;
    bit to;
    mon_cpb = 2;
    load_random(3);
    for (int k = 0; k < 3; k++) msg_d[8*k +: 8] = mb[k];
    pulse_start(3);
    run_to_ready(3, 5000, bc, rs, lc, to);
    model_bytes(3, 5, 0);
    mm = first_mismatch(base);
    checks++;
    if (to || bc != model_cycles(3, 2, 5, 0)) begin
      failures++; $display("[TB] FAIL zero_prefix_cycles got=%0d want=%0d", bc, model_cycles(3, 2, 5, 0));
    end
    checks++;
    if (mm != -1) begin
      failures++; $display("[TB] FAIL zero_prefix_bytes got=%0d bytes (bad idx %0d) want=%0d", rx_q.size() - base, mm, exp_q.size());
    end
    checks++;
    if (res_v[3] !== 4'd5) begin failures++; $display("[TB] FAIL zero_prefix_result got=%0d want=5", res_v[3]); end
  endtask

  initial begin
    reset   = 1'b1;
    start_v = '0;
    mon_rst = 1'b0;
    mon_cpb = 4;
    msg_a   = '0;
    msg_b   = '0;
    msg_c   = '0;
    msg_d   = '0;
    test_reset();
    test_bit_timing();
    test_full_run();
    test_ilast_zero();
    test_restart();
    test_reset_mid_run();
    test_prefix_saturation();
    test_zero_prefix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
